// File: rtl/riscv_ppreg_skid.sv
// Elastic pipeline stage register: valid/ready on both sides, one-entry skid
// buffer so upstream ready is registered, plus flush, occupancy and stall counter.
module riscv_ppreg_skid #(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned CLR_ON_FLUSH = 1
) (
  input  logic              i_riscv_pps_clk,
  input  logic              i_riscv_pps_rst_n,
  input  logic              i_riscv_pps_flush,
  input  logic              i_riscv_pps_valid,
  output logic              o_riscv_pps_ready,
  input  logic [DATA_W-1:0] i_riscv_pps_data,
  output logic              o_riscv_pps_valid,
  input  logic              i_riscv_pps_ready,
  output logic [DATA_W-1:0] o_riscv_pps_data,
  output logic [1:0]        o_riscv_pps_occupancy,
  input  logic              i_riscv_pps_cnt_clr,
  output logic [CNT_W-1:0]  o_riscv_pps_stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              valid_q;
  logic              ready_q;
  logic [1:0]        occ_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = i_riscv_pps_valid & ready_q;
  assign out_fire = valid_q & i_riscv_pps_ready;

  // valid/ready/occupancy are kept as their own flops rather than decoded from
  // state, so every output leaves a register with no combinational input path.
  always_ff @(posedge i_riscv_pps_clk or negedge i_riscv_pps_rst_n) begin
    if (!i_riscv_pps_rst_n) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      occ_q   <= 2'd0;
    end else if (i_riscv_pps_flush) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      occ_q   <= 2'd0;
      if (CLR_ON_FLUSH != 0) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q  <= i_riscv_pps_data;
            state   <= BUSY;
            valid_q <= 1'b1;
            occ_q   <= 2'd1;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_q <= i_riscv_pps_data;
          end else if (in_fire) begin
            skid_q  <= i_riscv_pps_data;
            state   <= FULL;
            ready_q <= 1'b0;
            occ_q   <= 2'd2;
          end else if (out_fire) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
            occ_q   <= 2'd0;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_q  <= skid_q;
            state   <= BUSY;
            ready_q <= 1'b1;
            occ_q   <= 2'd1;
          end
        end
        default: begin
          state   <= EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          occ_q   <= 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge i_riscv_pps_clk or negedge i_riscv_pps_rst_n) begin
    if (!i_riscv_pps_rst_n) begin
      cnt_q <= '0;
    end else if (i_riscv_pps_cnt_clr) begin
      cnt_q <= '0;
    end else if (valid_q && !i_riscv_pps_ready && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_riscv_pps_ready     = ready_q;
  assign o_riscv_pps_valid     = valid_q;
  assign o_riscv_pps_data      = main_q;
  assign o_riscv_pps_occupancy = occ_q;
  assign o_riscv_pps_stall_cnt = cnt_q;

endmodule

// File: tb/tb_riscv_ppreg_skid.sv
// Bench for riscv_ppreg_skid: two instances (narrow counter + clearing flush,
// wide counter + retaining flush) driven together and checked against a queue model.
module tb_riscv_ppreg_skid;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       valid = 1'b0;
  logic       rdy = 1'b0;
  logic [7:0] data = '0;
  logic       cnt_clr = 1'b0;

  logic       a_ready, a_valid, b_ready, b_valid;
  logic [7:0] a_data, b_data;
  logic [1:0] a_occ, b_occ;
  logic [1:0] a_cnt;
  logic [7:0] b_cnt;

  int total = 0;
  int bad = 0;

  // Reference model: queue of held payloads plus last head seen by each main register
  logic [7:0] q[$];
  logic [7:0] m_main_a = '0;
  logic [7:0] m_main_b = '0;
  logic [1:0] m_cnt_a = '0;
  logic [7:0] m_cnt_b = '0;

  always #5 clk = ~clk;

  riscv_ppreg_skid #(.DATA_W(8), .CNT_W(2), .CLR_ON_FLUSH(1)) dut (
    .i_riscv_pps_clk(clk), .i_riscv_pps_rst_n(rst_n), .i_riscv_pps_flush(flush),
    .i_riscv_pps_valid(valid), .o_riscv_pps_ready(a_ready), .i_riscv_pps_data(data),
    .o_riscv_pps_valid(a_valid), .i_riscv_pps_ready(rdy), .o_riscv_pps_data(a_data),
    .o_riscv_pps_occupancy(a_occ), .i_riscv_pps_cnt_clr(cnt_clr),
    .o_riscv_pps_stall_cnt(a_cnt)
  );

  riscv_ppreg_skid #(.DATA_W(8), .CNT_W(8), .CLR_ON_FLUSH(0)) dut_keep (
    .i_riscv_pps_clk(clk), .i_riscv_pps_rst_n(rst_n), .i_riscv_pps_flush(flush),
    .i_riscv_pps_valid(valid), .o_riscv_pps_ready(b_ready), .i_riscv_pps_data(data),
    .o_riscv_pps_valid(b_valid), .i_riscv_pps_ready(rdy), .o_riscv_pps_data(b_data),
    .o_riscv_pps_occupancy(b_occ), .i_riscv_pps_cnt_clr(cnt_clr),
    .o_riscv_pps_stall_cnt(b_cnt)
  );

  task automatic model_reset();
    q.delete();
    m_main_a = '0;
    m_main_b = '0;
    m_cnt_a  = '0;
    m_cnt_b  = '0;
  endtask

  // Advance one clock and apply the FIFO rules to the model; leaves time at posedge+1.
  task automatic clk_step();
    int unsigned sz;
    bit inf, outf;
    sz   = q.size();
    inf  = valid && (sz < 2);
    outf = (sz > 0) && rdy;
    @(posedge clk);
    #1;
    if (cnt_clr) begin
      m_cnt_a = '0;
      m_cnt_b = '0;
    end else if (sz > 0 && !rdy) begin
      if (m_cnt_a != 2'd3) m_cnt_a = m_cnt_a + 2'd1;
      if (m_cnt_b != 8'd255) m_cnt_b = m_cnt_b + 8'd1;
    end
    if (flush) begin
      q.delete();
      m_main_a = '0;
    end else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(data);
    end
    if (q.size() > 0) begin
      m_main_a = q[0];
      m_main_b = q[0];
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r,
                       input logic f, input logic c);
    valid = v; data = d; rdy = r; flush = f; cnt_clr = c;
  endtask

  task automatic test_reset();
    drive(0, 8'h00, 0, 0, 0);
    rst_n = 1'b0;
    #12;
    model_reset();
    total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", a_valid); end
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", a_ready); end
    total++; if (a_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", a_data); end
    total++; if (a_occ !== 2'd0 || a_cnt !== 2'd0) begin bad++; $display("FAIL reset_occ_cnt got=%0d/%0d want=0/0", a_occ, a_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 8; i++) begin
      drive(1, 8'h11 + 8'(i), 1, 0, 0);
      clk_step();
      total++;
      if (a_valid !== 1'b1 || a_data !== 8'h11 + 8'(i) || a_data !== m_main_a)
        begin bad++; $display("FAIL stream_data[%0d] got=%b/%h want=1/%h", i, a_valid, a_data, 8'h11 + 8'(i)); end
      total++;
      if (a_ready !== 1'b1 || a_occ !== 2'd1 || a_cnt !== 2'd0)
        begin bad++; $display("FAIL stream_flags[%0d] got=%b/%0d/%0d want=1/1/0", i, a_ready, a_occ, a_cnt); end
    end
    drive(0, 8'h00, 1, 0, 0);
    clk_step();
    total++; if (a_valid !== 1'b0 || a_occ !== 2'd0) begin bad++; $display("FAIL stream_drain got=%b/%0d want=0/0", a_valid, a_occ); end
  endtask

  task automatic test_back_pressure();
    drive(0, 8'h00, 0, 0, 1);
    clk_step();
    drive(1, 8'h0A, 0, 0, 0);
    clk_step();
    drive(1, 8'h0B, 0, 0, 0);
    clk_step();
    total++;
    if (a_occ !== 2'd2 || a_ready !== 1'b0 || a_data !== 8'h0A)
      begin bad++; $display("FAIL bp_full got=%0d/%b/%h want=2/0/0a", a_occ, a_ready, a_data); end
    drive(0, 8'h00, 0, 0, 0);
    clk_step();
    total++; if (a_data !== 8'h0A || b_cnt !== m_cnt_b) begin bad++; $display("FAIL bp_hold got=%h/%0d want=0a/%0d", a_data, b_cnt, m_cnt_b); end
    drive(0, 8'h00, 1, 0, 0);
    clk_step();
    total++;
    if (a_data !== 8'h0B || a_occ !== 2'd1 || a_ready !== 1'b1)
      begin bad++; $display("FAIL bp_second got=%h/%0d/%b want=0b/1/1", a_data, a_occ, a_ready); end
    clk_step();
    total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", a_valid); end
    total++; if (b_cnt !== 8'd2 || a_cnt !== 2'd2) begin bad++; $display("FAIL bp_stall_cnt got=%0d/%0d want=2/2", b_cnt, a_cnt); end
  endtask

  task automatic test_flush_full();
    drive(1, 8'h0A, 0, 0, 0);
    clk_step();
    drive(1, 8'h0B, 0, 0, 0);
    clk_step();
    drive(1, 8'h0C, 0, 1, 0);
    clk_step();
    total++;
    if (a_valid !== 1'b0 || a_ready !== 1'b1 || a_occ !== 2'd0)
      begin bad++; $display("FAIL flush_full_state got=%b/%b/%0d want=0/1/0", a_valid, a_ready, a_occ); end
    total++; if (a_data !== 8'h00) begin bad++; $display("FAIL flush_clear_data got=%h want=00", a_data); end
    total++; if (b_data !== 8'h0A || b_data !== m_main_b) begin bad++; $display("FAIL flush_keep_data got=%h want=0a", b_data); end
    drive(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      clk_step();
      total++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin bad++; $display("FAIL flush_no_leak[%0d] got=%b/%b want=0/0", i, a_valid, b_valid); end
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 8'h03, 0, 0, 0);
    clk_step();
    drive(1, 8'h04, 0, 0, 0);
    clk_step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (a_valid !== 1'b0 || a_occ !== 2'd0 || a_data !== 8'h00 || a_ready !== 1'b1)
      begin bad++; $display("FAIL reset_mid got=%b/%0d/%h/%b want=0/0/00/1", a_valid, a_occ, a_data, a_ready); end
    @(negedge clk);
    drive(0, 8'h00, 1, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (a_valid !== 1'b0 || b_data !== 8'h00) begin bad++; $display("FAIL reset_release got=%b/%h want=0/00", a_valid, b_data); end
    drive(1, 8'h05, 1, 0, 0);
    clk_step();
    total++; if (a_valid !== 1'b1 || a_data !== 8'h05) begin bad++; $display("FAIL reset_first_push got=%b/%h want=1/05", a_valid, a_data); end
    drive(0, 8'h00, 1, 0, 0);
    clk_step();
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat [6];
    exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    drive(1, 8'h07, 0, 0, 1);
    clk_step();
    drive(0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      clk_step();
      total++;
      if (a_cnt !== exp_sat[i] || a_cnt !== m_cnt_a)
        begin bad++; $display("FAIL sat_cnt[%0d] got=%0d want=%0d", i, a_cnt, exp_sat[i]); end
    end
    drive(0, 8'h00, 0, 0, 1);
    clk_step();
    total++; if (a_cnt !== 2'd0 || b_cnt !== 8'd0) begin bad++; $display("FAIL sat_clr got=%0d/%0d want=0/0", a_cnt, b_cnt); end
    drive(0, 8'h00, 0, 0, 0);
    clk_step();
    total++; if (a_cnt !== 2'd1) begin bad++; $display("FAIL sat_recount got=%0d want=1", a_cnt); end
    drive(0, 8'h00, 1, 0, 0);
    clk_step();
  endtask

  task automatic test_flush_out_fire();
    drive(1, 8'h05, 1, 0, 0);
    clk_step();
    total++; if (a_valid !== 1'b1 || a_data !== 8'h05) begin bad++; $display("FAIL fof_busy got=%b/%h want=1/05", a_valid, a_data); end
    drive(0, 8'h00, 1, 1, 0);
    clk_step();
    total++; if (a_valid !== 1'b0 || a_occ !== 2'd0 || b_data !== 8'h05) begin bad++; $display("FAIL fof_empty got=%b/%0d/%h want=0/0/05", a_valid, a_occ, b_data); end
    drive(0, 8'h00, 1, 0, 0);
    clk_step();
    total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL fof_no_dup got=%b want=0", a_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 55),
            1'($urandom_range(0, 99) < 4), 1'($urandom_range(0, 99) < 3));
      clk_step();
      total++;
      if (a_valid !== (q.size() > 0) || a_occ !== 2'(q.size()) || a_ready !== (q.size() < 2))
        begin bad++; $display("FAIL rand_ctl[%0d] got=%b/%0d/%b want=%b/%0d/%b", i, a_valid, a_occ, a_ready, q.size() > 0, q.size(), q.size() < 2); end
      total++;
      if (a_data !== m_main_a || b_data !== m_main_b)
        begin bad++; $display("FAIL rand_data[%0d] got=%h/%h want=%h/%h", i, a_data, b_data, m_main_a, m_main_b); end
      total++;
      if (a_cnt !== m_cnt_a || b_cnt !== m_cnt_b || b_occ !== a_occ)
        begin bad++; $display("FAIL rand_cnt[%0d] got=%0d/%0d want=%0d/%0d", i, a_cnt, b_cnt, m_cnt_a, m_cnt_b); end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush_full();
    test_reset_mid();
    test_saturation();
    test_flush_out_fire();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_ppreg_skid.md
Name: riscv_ppreg_skid

Overview:
Parametrised, elastic successor to the fixed-field stage registers. It is a single pipeline stage register with a valid/ready handshake on both sides and a one-entry skid buffer, so the stage sustains one transfer per cycle with a registered upstream ready. It adds a synchronous flush, an occupancy readout and a saturating back-pressure counter. Stage payloads are packed into one DATA_W bus, so it can be instantiated between any two core stages (e.g. execute→memory).

Parameters:
DATA_W, 64, payload width in bits (≥1)
CNT_W, 32, width of the back-pressure stall counter (≥2)
CLR_ON_FLUSH, 1, 1: flush zeroes both data registers; 0: flush only clears valid bits

Ports:
i_riscv_pps_clk  in  1  clock; all state updates on rising edge
i_riscv_pps_rst_n  in  1  reset; asynchronous assert, active-low
i_riscv_pps_flush  in  1  synchronous flush; discards all held and incoming entries
i_riscv_pps_valid  in  1  upstream payload valid
o_riscv_pps_ready  out  1  upstream ready; registered, equals "skid entry empty"
i_riscv_pps_data  in  DATA_W  upstream payload
o_riscv_pps_valid  out  1  downstream payload valid; equals main entry valid
i_riscv_pps_ready  in  1  downstream ready
o_riscv_pps_data  out  DATA_W  downstream payload; driven straight from the main register
o_riscv_pps_occupancy  out  2  number of held entries (0, 1 or 2)
i_riscv_pps_cnt_clr  in  1  synchronous clear of the stall counter
o_riscv_pps_stall_cnt  out  CNT_W  cycles with o_valid=1 and i_ready=0, saturating

Behaviour:
- Reset (rst_n=0, asynchronous): state EMPTY; o_valid=0; o_ready=1; o_data=0; skid data=0; occupancy=0; stall_cnt=0. Reset can assert mid-transfer. The held entries are lost, and no output glitches back to a prior value after release.
- Handshake events: in_fire = i_valid & o_ready. out_fire = o_valid & i_ready. Payload ordering is strictly FIFO. No combinational path from i_ready to o_ready, or from i_valid to o_valid.
- States: EMPTY (occupancy 0), BUSY (main valid, occupancy 1), FULL (main and skid valid, occupancy 2, o_ready=0).
- EMPTY transitions:
  - in_fire: main<=i_data, go to BUSY.
  - Otherwise hold.
- BUSY transitions:
  - in_fire & out_fire: main<=i_data, stay in BUSY.
  - in_fire & !out_fire: skid<=i_data, go to FULL, o_ready falls next cycle.
  - !in_fire & out_fire: go to EMPTY.
  - Otherwise hold.
- FULL transitions:
  - out_fire: main<=skid, go to BUSY, o_ready rises next cycle.
  - Otherwise hold.
  - i_valid is ignored in FULL.
- Latency: 1 cycle from in_fire to o_valid when the stage is empty. Throughput is 1 transfer/cycle in steady state.
- Flush (priority above all handshake activity, below reset):
  - Next state is EMPTY: o_valid=0, o_ready=1, occupancy=0.
  - A payload offered with o_ready=1 in the flush cycle counts as consumed upstream but is discarded.
  - A downstream transfer with i_ready=1 in the flush cycle counts as completed.
  - CLR_ON_FLUSH=1: main and skid data registers are zeroed. CLR_ON_FLUSH=0: data registers are untouched.
- Data registers update only on the transitions listed above. Holding states leave o_data stable while o_valid=1 and i_ready=0.
- Stall counter:
  - Increments by 1 in each cycle with o_valid=1 and i_ready=0.
  - Saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr has priority and sets it to 0 that cycle, with no increment.
  - Flush does not clear the counter. The flush cycle itself still counts if its condition holds.
- Occupancy is registered and consistent with the state at every edge. The value 3 never appears.

Test Plan:
- Streaming: i_ready=1, push 0x11..0x18 on consecutive cycles → o_data shows 0x11..0x18 one cycle later, back-to-back; o_ready stays 1; occupancy stays 1; stall_cnt=0.
- Back-pressure: push 0xA then 0xB with i_ready=0 → FULL, occupancy=2, o_ready=0 from the cycle after 0xB is accepted, o_data holds 0xA. Raise i_ready → 0xA then 0xB out in order; stall_cnt equals the number of cycles i_ready was low with o_valid=1.
- Flush while FULL, i_valid=1 with data 0xC → next cycle o_valid=0, o_ready=1, occupancy=0; o_data=0 with CLR_ON_FLUSH=1 (retains 0xA with 0); 0xC never appears downstream.
- Reset mid-stream: assert rst_n=0 asynchronously between edges while FULL → o_valid, occupancy and o_data go to 0 immediately, o_ready=1; after release, the first new push emerges correctly.
- Counter saturation (CNT_W=2): hold o_valid=1, i_ready=0 for 6 cycles → stall_cnt 1,2,3,3,3,3. Assert cnt_clr with the stall still active → 0 that cycle, then counts again from 1.
- Flush with simultaneous out_fire in BUSY (i_ready=1, o_data=0x5) → 0x5 counted as delivered, state EMPTY next cycle, no duplicate output.
